// File: rtl/rotate_rr_arbiter.sv
// Round-robin arbiter sharing one 8-bit rotate-right datapath among N_REQ requesters,
// with a single registered, back-pressurable response slot.
module rotate_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [3*N_REQ-1:0]   req_amt,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [7:0]           rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 dbg_slot_full,
    output logic [ID_W-1:0]      dbg_last_grant
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // req_ready is one-hot or zero and may depend on req_valid/rsp_ready; rsp_* are registered.

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_e;

    slot_state_e       state_q, state_d;
    logic [7:0]        rsp_data_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic [ID_W-1:0]   last_grant_q;

    logic              found;
    logic [ID_W-1:0]   grant_idx;
    logic              can_accept;
    logic              accept;
    logic [7:0]        sel_data;
    logic [2:0]        sel_amt;
    logic [7:0]        rot_s0, rot_s1, rot_s2;

    // Two passes give the rotating priority: indices above last_grant first, then from 0.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && (i > int'(last_grant_q)) && req_valid[i]) begin
                found     = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req_valid[i]) begin
                found     = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
    end

    assign can_accept = (state_q == S_EMPTY) || rsp_ready;
    assign accept     = rst_n && can_accept && found;

    always_comb begin
        req_ready = '0;
        sel_data  = '0;
        sel_amt   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                req_ready[i] = accept;
                sel_data     = req_data[8*i +: 8];
                sel_amt      = req_amt[3*i +: 3];
            end
        end
    end

    assign rot_s0 = sel_amt[0] ? {sel_data[0],   sel_data[7:1]} : sel_data;
    assign rot_s1 = sel_amt[1] ? {rot_s0[1:0],   rot_s0[7:2]}   : rot_s0;
    assign rot_s2 = sel_amt[2] ? {rot_s1[3:0],   rot_s1[7:4]}   : rot_s1;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (accept) state_d = S_FULL;
            S_FULL:  if (rsp_ready && !accept) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_EMPTY;
            rsp_data_q   <= 8'h00;
            rsp_id_q     <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            if (accept) begin
                rsp_data_q   <= rot_s2;
                rsp_id_q     <= grant_idx;
                last_grant_q <= grant_idx;
            end
        end
    end

    assign rsp_valid      = (state_q == S_FULL);
    assign rsp_data       = rsp_data_q;
    assign rsp_id         = rsp_id_q;
    assign dbg_slot_full  = (state_q == S_FULL);
    assign dbg_last_grant = last_grant_q;

endmodule

// File: tb/tb_rotate_rr_arbiter.sv
// Bench for rotate_rr_arbiter: directed scenarios plus randomized traffic, checked by a
// queue-based scoreboard fed from a behavioural round-robin/rotate model.
module tb_rotate_rr_arbiter;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [8*N-1:0]    req_data;
    logic [3*N-1:0]    req_amt;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [7:0]        rsp_data;
    logic [ID_W-1:0]   rsp_id;
    logic              dbg_slot_full;
    logic [ID_W-1:0]   dbg_last_grant;

    rotate_rr_arbiter #(.N_REQ(N), .ID_W(ID_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .req_amt        (req_amt),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_id         (rsp_id),
        .dbg_slot_full  (dbg_slot_full),
        .dbg_last_grant (dbg_last_grant)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [ID_W+7:0] exp_q[$];

    // requester-side pending operations and model state
    logic            pend_v[N];
    logic [7:0]      pend_d[N];
    logic [2:0]      pend_a[N];
    logic            m_full;
    int              m_last;
    logic [N-1:0]    seen_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rotr(input logic [7:0] a, input int amt);
        logic [15:0] w;
        w = {a, a} >> amt;
        return w[7:0];
    endfunction

    // One clock cycle: drive at negedge, predict and check, then wait for the edge.
    task automatic step(input logic rr, input logic rst_val);
        int win;
        logic [N-1:0] exp_rdy;
        @(negedge clk);
        rst_n     = rst_val;
        rsp_ready = rr;
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend_v[i];
            req_data[8*i +: 8] = pend_d[i];
            req_amt[3*i +: 3]  = pend_a[i];
        end
        #1;
        win = -1;
        if (rst_val) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_last + k) % N;
                if (win < 0 && pend_v[idx]) win = idx;
            end
        end
        exp_rdy = '0;
        if (rst_val && (!m_full || rr) && win >= 0) exp_rdy[win] = 1'b1;
        seen_rdy = req_ready;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (rst_val) chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
        if (!rst_val) begin
            m_full = 1'b0;
            m_last = N - 1;
            exp_q.delete();
        end else if (exp_rdy != '0) begin
            exp_q.push_back({ID_W'(win), rotr(pend_d[win], int'(pend_a[win]))});
            m_last      = win;
            pend_v[win] = 1'b0;
            m_full      = 1'b1;
        end else if (rr) begin
            m_full = 1'b0;
        end
        @(posedge clk);
    endtask

    task automatic set_op(input int i, input logic [7:0] d, input logic [2:0] a);
        pend_v[i] = 1'b1;
        pend_d[i] = d;
        pend_a[i] = a;
    endtask

    task automatic clear_ops();
        for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
    endtask

    // scoreboard monitor: pops on every response handshake
    always @(negedge clk) begin
        logic [ID_W+7:0] e;
        #2;
        if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(e[7:0]));
                chk("rsp_id",   32'(rsp_id),   32'(e[ID_W+7:8]));
            end
        end
    end

    logic [7:0] sw_d[4];
    logic [2:0] sw_a[4];
    logic [7:0] sw_r[4];

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b0;
        req_valid = '0; req_data = '0; req_amt = '0;
        m_full = 1'b0; m_last = N - 1; seen_rdy = '0;
        for (int i = 0; i < N; i++) begin pend_v[i] = 0; pend_d[i] = 0; pend_a[i] = 0; end

        // reset state
        step(1'b1, 1'b0);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        chk("rst_rsp_id",    32'(rsp_id),    32'd0);
        chk("rst_last_grant", 32'(dbg_last_grant), 32'(N - 1));

        // first operation
        set_op(0, 8'h81, 3'd1);
        step(1'b1, 1'b1);
        chk("t1_ready", 32'(seen_rdy), 32'b0001);
        #1;
        chk("t1_valid", 32'(rsp_valid), 32'd1);
        chk("t1_data",  32'(rsp_data),  32'hC0);
        chk("t1_id",    32'(rsp_id),    32'd0);
        step(1'b1, 1'b1);

        // rotate sweep on requester 2, back to back
        sw_d = '{8'hA5, 8'h12, 8'h80, 8'h01};
        sw_a = '{3'd0, 3'd4, 3'd3, 3'd7};
        sw_r = '{8'hA5, 8'h21, 8'h10, 8'h02};
        for (int s = 0; s < 4; s++) begin
            set_op(2, sw_d[s], sw_a[s]);
            step(1'b1, 1'b1);
            chk("sweep_ready", 32'(seen_rdy), 32'b0100);
            #1;
            chk("sweep_data", 32'(rsp_data), 32'(sw_r[s]));
            chk("sweep_id",   32'(rsp_id),   32'd2);
        end
        step(1'b1, 1'b1);

        // all requesters valid from reset
        step(1'b1, 1'b0);
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend_v[i]) set_op(i, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
            step(1'b1, 1'b1);
            #1;
            chk("all_valid", 32'(rsp_valid), 32'd1);
            chk("all_id",    32'(rsp_id),    32'(c % N));
        end
        clear_ops();
        step(1'b1, 1'b1);

        // back-pressure: slot holds 3C from requester 1 while requester 3 waits
        set_op(1, 8'h3C, 3'd0);
        step(1'b0, 1'b1);
        set_op(3, 8'h5A, 3'd2);
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b1);
            chk("bp_ready", 32'(seen_rdy), 32'd0);
            #1;
            chk("bp_data", 32'(rsp_data), 32'h3C);
            chk("bp_id",   32'(rsp_id),   32'd1);
        end
        step(1'b1, 1'b1);
        chk("bp_release", 32'(seen_rdy), 32'b1000);
        #1;
        chk("bp_new_data", 32'(rsp_data), 32'h96);
        step(1'b1, 1'b1);

        // last_grant = 1 with requesters 0 and 3 valid
        set_op(1, 8'h11, 3'd1);
        step(1'b1, 1'b1);
        set_op(0, 8'h0F, 3'd5);
        set_op(3, 8'hF0, 3'd6);
        step(1'b1, 1'b1);
        chk("rr_first",  32'(seen_rdy), 32'b1000);
        step(1'b1, 1'b1);
        chk("rr_second", 32'(seen_rdy), 32'b0001);
        step(1'b1, 1'b1);

        // reset with a full slot discards it; requester 0 wins afterwards
        set_op(2, 8'h77, 3'd3);
        step(1'b0, 1'b1);
        set_op(0, 8'hAA, 3'd1);
        set_op(1, 8'hBB, 3'd2);
        step(1'b1, 1'b0);
        chk("mid_rst_ready", 32'(seen_rdy), 32'd0);
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_data",  32'(rsp_data),  32'd0);
        chk("mid_rst_id",    32'(rsp_id),    32'd0);
        step(1'b1, 1'b1);
        chk("post_rst_grant", 32'(seen_rdy), 32'b0001);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);

        // randomized traffic with occasional reset
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                if (!pend_v[i] && $urandom_range(0, 1) == 1)
                    set_op(i, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
            step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) != 0));
        end

        clear_ops();
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
